// File: rtl/qif_pkg.sv
// Shared widths, FSM state encoding and the saturating narrow function for the
// QIF synapse driver.
package qif_pkg;

    localparam int I_W   = 8;
    localparam int SUM_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DECAY = 2'd2
    } state_t;

    function automatic logic signed [I_W-1:0] sat8(input logic signed [SUM_W-1:0] v);
        logic signed [I_W-1:0] r;
        if (v > 9'sd127) begin
            r = 8'sd127;
        end else if (v < -9'sd128) begin
            r = -8'sd128;
        end else begin
            r = v[I_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/qif_event_fifo.sv
// 4-deep, 2-bit-wide spike event FIFO. Pointers carry an extra wrap bit so full
// and empty are told apart without a separate count.
module qif_event_fifo (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [1:0] i_data,
    input  logic       i_pop,
    output logic [1:0] o_data,
    output logic       o_full,
    output logic       o_empty
);

    logic [1:0] r_mem [4];
    logic [2:0] r_wr_ptr;
    logic [2:0] r_rd_ptr;
    logic       w_do_push;
    logic       w_do_pop;

    assign o_full    = (r_wr_ptr[2] != r_rd_ptr[2]) && (r_wr_ptr[1:0] == r_rd_ptr[1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 3'd1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[1:0]] <= i_data;
    end

endmodule

// File: rtl/qif_synapse_driver.sv
// Synapse driver for the QIF neuron: queues spike events, adds per-synapse weights into a
// saturating 8-bit current, and leaks that current toward zero once per decay tick.
module qif_synapse_driver
    import qif_pkg::*;
#(
    parameter int                TICK_DIV    = 16,
    parameter int                DECAY_SHIFT = 2,
    parameter logic signed [7:0] WEIGHT_INIT = 8'sd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spike_valid,
    input  logic [1:0] spike_syn,
    output logic       spike_ready,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] i_syn,
    output logic       i_syn_valid,
    output logic       sat_flag,
    output logic [1:0] o_dbg_state
);

    localparam int               CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    // valid/ready: an event transfers on a rising edge where spike_valid && spike_ready;
    // spike_ready depends only on FIFO fullness, never on spike_valid or a same-cycle pop.
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [1:0]              w_fifo_data;
    logic                    w_pop;
    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_tick_cnt;
    logic                    r_tick_pending;
    logic                    w_tick_wrap;
    logic signed [I_W-1:0]   r_weight [4];
    logic [1:0]              r_idx;
    logic signed [I_W-1:0]   r_i_syn;
    logic                    r_i_syn_valid;
    logic                    r_sat;
    logic signed [SUM_W-1:0] w_cur_ext;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_mag;
    logic signed [SUM_W-1:0] w_dec;
    logic signed [I_W-1:0]   w_decayed;
    logic signed [I_W-1:0]   w_i_syn_next;
    logic                    w_sat_hit;

    assign spike_ready = !w_fifo_full;
    assign i_syn       = r_i_syn;
    assign i_syn_valid = r_i_syn_valid;
    assign sat_flag    = r_sat;
    assign o_dbg_state = r_state;

    qif_event_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (spike_valid && spike_ready),
        .i_data  (spike_syn),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_tick_wrap = (r_tick_cnt == CNT_MAX);

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_tick_pending) begin
                    w_state_next = DECAY;
                end else if (!w_fifo_empty) begin
                    w_state_next = APPLY;
                    w_pop        = 1'b1;
                end
            end
            APPLY:   w_state_next = IDLE;
            DECAY:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Magnitude is taken in 9 bits so that -128 decays like any other value.
    assign w_cur_ext = {r_i_syn[I_W-1], r_i_syn};
    assign w_sum     = w_cur_ext + {r_weight[r_idx][I_W-1], r_weight[r_idx]};
    assign w_mag     = r_i_syn[I_W-1] ? -w_cur_ext : w_cur_ext;

    always_comb begin
        w_dec = w_mag >>> DECAY_SHIFT;
        if (w_dec == '0 && w_mag != '0) w_dec = 9'sd1;
    end

    assign w_decayed = r_i_syn[I_W-1] ? (r_i_syn + w_dec[I_W-1:0]) : (r_i_syn - w_dec[I_W-1:0]);
    assign w_sat_hit = (r_state == APPLY) && ((w_sum > 9'sd127) || (w_sum < -9'sd128));

    always_comb begin
        w_i_syn_next = r_i_syn;
        case (r_state)
            APPLY:   w_i_syn_next = sat8(w_sum);
            DECAY:   w_i_syn_next = w_decayed;
            default: w_i_syn_next = r_i_syn;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_tick_cnt     <= '0;
            r_tick_pending <= 1'b0;
            r_idx          <= 2'd0;
            r_i_syn        <= '0;
            r_i_syn_valid  <= 1'b0;
            r_sat          <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_tick_cnt    <= w_tick_wrap ? '0 : r_tick_cnt + CNT_W'(1);
            r_i_syn       <= w_i_syn_next;
            r_i_syn_valid <= (w_i_syn_next != r_i_syn);
            r_sat         <= r_sat | w_sat_hit;
            if (w_pop) r_idx <= w_fifo_data;
            // A wrap landing on the servicing edge re-arms rather than being lost.
            if (w_tick_wrap) begin
                r_tick_pending <= 1'b1;
            end else if (r_state == DECAY) begin
                r_tick_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_weight[i] <= WEIGHT_INIT;
        end else if (wr_en) begin
            r_weight[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_qif_synapse_driver.sv
// Bench for qif_synapse_driver: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of the driver.
module tb_qif_synapse_driver;

    localparam int TICK_DIV    = 16;
    localparam int DECAY_SHIFT = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       spike_valid;
    logic [1:0] spike_syn;
    logic       spike_ready;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] i_syn;
    logic       i_syn_valid;
    logic       sat_flag;
    logic [1:0] o_dbg_state;

    always #5 clk = ~clk;

    qif_synapse_driver #(
        .TICK_DIV    (TICK_DIV),
        .DECAY_SHIFT (DECAY_SHIFT),
        .WEIGHT_INIT (8'sd16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .spike_valid (spike_valid),
        .spike_syn   (spike_syn),
        .spike_ready (spike_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .i_syn       (i_syn),
        .i_syn_valid (i_syn_valid),
        .sat_flag    (sat_flag),
        .o_dbg_state (o_dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_q[$];
    int exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queued event list, weight table, current value, and at most
    // one operation in flight that lands one edge after it is chosen.
    int m_q[$];
    int m_w[4];
    int m_isyn;
    int m_cnt;
    int m_idx;
    bit m_sat;
    bit m_pending;
    bit m_busy;
    bit m_op_decay;
    bit m_changed;

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < 4; i++) m_w[i] = 16;
        m_isyn = 0; m_cnt = 0; m_idx = 0;
        m_sat = 0; m_pending = 0; m_busy = 0; m_op_decay = 0; m_changed = 0;
    endfunction

    function automatic void model_edge();
        bit acc;
        int old;
        int mag;
        int d;
        int s;
        acc = spike_valid && (m_q.size() < 4);
        m_changed = 0;
        if (m_busy) begin
            old = m_isyn;
            if (m_op_decay) begin
                mag = (m_isyn < 0) ? -m_isyn : m_isyn;
                d = mag >> DECAY_SHIFT;
                if (d == 0 && mag != 0) d = 1;
                m_isyn = (m_isyn < 0) ? m_isyn + d : m_isyn - d;
                m_pending = 0;
            end else begin
                s = m_isyn + m_w[m_idx];
                if (s > 127) begin s = 127; m_sat = 1; end
                if (s < -128) begin s = -128; m_sat = 1; end
                m_isyn = s;
            end
            m_changed = (m_isyn != old);
            m_busy = 0;
        end else if (m_pending) begin
            m_busy = 1; m_op_decay = 1;
        end else if (m_q.size() > 0) begin
            m_busy = 1; m_op_decay = 0;
            m_idx = m_q.pop_front();
        end
        if (acc) m_q.push_back(int'(spike_syn));
        if (m_cnt == TICK_DIV - 1) begin
            m_cnt = 0;
            m_pending = 1;
        end else begin
            m_cnt++;
        end
        if (wr_en) m_w[wr_addr] = int'($signed(wr_data));
    endfunction

    task automatic compare_outputs();
        check("i_syn", int'($signed(i_syn)), m_isyn);
        check("i_syn_valid", int'(i_syn_valid), int'(m_changed));
        check("sat_flag", int'(sat_flag), int'(m_sat));
        check("spike_ready", int'(spike_ready), int'(m_q.size() < 4));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_edge();
        @(negedge clk);
        compare_outputs();
        if (i_syn_valid) pulse_q.push_back(int'($signed(i_syn)));
    endtask

    task automatic idle(input int n);
        spike_valid = 1'b0;
        wr_en = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic spike(input int s);
        spike_valid = 1'b1;
        spike_syn = 2'(s);
        cycle();
        spike_valid = 1'b0;
    endtask

    task automatic write_w(input int a, input int d);
        wr_en = 1'b1;
        wr_addr = 2'(a);
        wr_data = 8'(d);
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        spike_valid = 1'b0;
        wr_en = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        repeat (2) cycle();
        reset = 1'b0;
        pulse_q.delete();
    endtask

    task automatic check_pulses(input string tag);
        check({tag, "_count"}, pulse_q.size(), exp_q.size());
        for (int i = 0; i < pulse_q.size() && i < exp_q.size(); i++)
            check({tag, "_value"}, pulse_q[i], exp_q[i]);
    endtask

    initial begin
        int acc_cnt;
        int inc_cnt;
        int dec_sum;
        int prev;
        bit saw_full;

        reset = 1'b0; spike_valid = 1'b0; spike_syn = 2'd0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'd0;
        @(negedge clk);

        // Reset values and default weights read back through single spikes.
        do_reset();
        check("rst_i_syn", int'($signed(i_syn)), 0);
        check("rst_sat", int'(sat_flag), 0);
        check("rst_ready", int'(spike_ready), 1);
        for (int s = 0; s < 4; s++) begin
            spike(s);
            idle(2);
            check("weight_init", int'($signed(i_syn)), 16 * (s + 1));
        end

        // Single spike latency and one-cycle valid pulse.
        do_reset();
        spike(0);
        idle(2);
        check("lat_i_syn", int'($signed(i_syn)), 16);
        check("lat_valid", int'(i_syn_valid), 1);
        idle(1);
        check("lat_valid_drop", int'(i_syn_valid), 0);

        // Decay chain from 16 down to 0, then silence.
        do_reset();
        spike(0);
        idle(200);
        exp_q = '{16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};
        check_pulses("decay_chain");
        idle(64);
        check("decay_quiet", pulse_q.size(), 11);

        // Positive saturation.
        do_reset();
        write_w(3, 127);
        spike(3);
        spike(3);
        idle(6);
        check("sat_pos_i_syn", int'($signed(i_syn)), 127);
        check("sat_pos_flag", int'(sat_flag), 1);

        // Negative saturation and decay from -128.
        do_reset();
        write_w(2, -128);
        spike(2);
        spike(2);
        spike(2);
        idle(6);
        check("sat_neg_i_syn", int'($signed(i_syn)), -128);
        check("sat_neg_flag", int'(sat_flag), 1);
        idle(8);
        check("decay_min", int'($signed(i_syn)), -96);

        // Back-pressure: hold valid for 10 cycles on a unit-weight synapse.
        do_reset();
        write_w(1, 1);
        acc_cnt = 0;
        saw_full = 0;
        spike_syn = 2'd1;
        for (int n = 0; n < 10; n++) begin
            spike_valid = 1'b1;
            if (spike_ready) acc_cnt++;
            else saw_full = 1;
            cycle();
        end
        idle(60);
        check("bp_ready_dropped", int'(saw_full), 1);
        inc_cnt = 0; dec_sum = 0; prev = 0;
        foreach (pulse_q[i]) begin
            if (pulse_q[i] > prev) inc_cnt++;
            else dec_sum += prev - pulse_q[i];
            prev = pulse_q[i];
        end
        check("bp_no_loss", inc_cnt, acc_cnt);
        check("bp_final", int'($signed(i_syn)), acc_cnt - dec_sum);

        // Reset with events queued and a tick pending.
        do_reset();
        idle(14);
        spike_syn = 2'd0;
        spike_valid = 1'b1;
        repeat (4) cycle();
        check("mid_queue_depth", m_q.size(), 3);
        check("mid_pending", int'(m_pending), 1);
        do_reset();
        check("mid_rst_i_syn", int'($signed(i_syn)), 0);
        check("mid_rst_ready", int'(spike_ready), 1);
        spike(0);
        idle(2);
        check("mid_first_spike", int'($signed(i_syn)), 16);
        idle(6);
        check("mid_no_stale", int'($signed(i_syn)), 16);

        // Tick wrap on the same edge as a push: decay first, then apply.
        do_reset();
        spike(0);
        idle(14);
        spike(1);
        idle(6);
        exp_q = '{16, 12, 28};
        check_pulses("wrap_vs_push");

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            spike_valid = ($urandom_range(0, 2) == 0);
            spike_syn   = 2'($urandom_range(0, 3));
            wr_en       = ($urandom_range(0, 15) == 0);
            wr_addr     = 2'($urandom_range(0, 3));
            wr_data     = 8'($urandom_range(0, 255));
            cycle();
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
